// File: rtl/lsu_pkg.sv
// Shared size encodings and FSM state type for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RVALID
  } lsu_state_e;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic: legality/alignment, byte enables, store replication
// and load extraction with sign/zero extension.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata_in,
  output logic        legal,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_size,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    legal = 1'b0;
    be    = 4'b0000;
    wdata = wdata_in;
    case (size[1:0])
      2'b00: begin
        be    = 4'b0001 << offset;
        wdata = {4{wdata_in[7:0]}};
        legal = 1'b1;
      end
      2'b01: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wdata_in[15:0]}};
        legal = !offset[0];
      end
      2'b10: begin
        be    = 4'b1111;
        legal = (offset == 2'b00);
      end
      default: legal = 1'b0;
    endcase
    // Unsigned variants exist only for byte/half loads.
    if (size[2] && (we || size[1]))
      legal = 1'b0;
  end

  assign ld_shift = rdata >> {ld_offset, 3'b000};
  assign ld_byte  = ld_shift[7:0];
  assign ld_half  = ld_offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (ld_size)
      LDST_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      LDST_H:  ld_data = {{16{ld_half[15]}}, ld_half};
      LDST_BU: ld_data = {24'h000000, ld_byte};
      LDST_HU: ld_data = {16'h0000, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns core byte/half/word accesses into word-aligned
// req/gnt/rvalid memory transactions and stalls the core until completion.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_data_i,
  output logic [31:0]       lsu_data_o,
  output logic              lsu_stall_req_o,
  output logic              lsu_err_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [31:0]       data_wdata_o,
  input  logic [31:0]       data_rdata_i
);

  lsu_state_e  state;
  logic [2:0]  size_q;
  logic [1:0]  offset_q;
  logic        legal;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ld_data;
  logic        accept;

  lsu_data_align u_align (
    .we        (lsu_we_i),
    .size      (lsu_size_i),
    .offset    (lsu_addr_i[1:0]),
    .wdata_in  (lsu_data_i),
    .legal     (legal),
    .be        (be),
    .wdata     (wdata),
    .ld_size   (size_q),
    .ld_offset (offset_q),
    .rdata     (data_rdata_i),
    .ld_data   (ld_data)
  );

  assign accept    = (state == IDLE) && lsu_req_i && legal;
  assign lsu_err_o = (state == IDLE) && lsu_req_i && !legal;

  always_comb begin
    case (state)
      IDLE:        lsu_stall_req_o = accept;
      REQ:         lsu_stall_req_o = 1'b1;
      WAIT_RVALID: lsu_stall_req_o = !data_rvalid_i;
      default:     lsu_stall_req_o = 1'b0;
    endcase
  end

  // data_we_o is held through WAIT_RVALID, so it doubles as the load/store flag.
  assign lsu_data_o = (state == WAIT_RVALID && data_rvalid_i && !data_we_o) ? ld_data : 32'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'b0000;
      data_addr_o  <= '0;
      data_wdata_o <= 32'h0;
      size_q       <= 3'b000;
      offset_q     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= REQ;
            data_req_o   <= 1'b1;
            data_we_o    <= lsu_we_i;
            data_be_o    <= be;
            data_addr_o  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
            data_wdata_o <= wdata;
            size_q       <= lsu_size_i;
            offset_q     <= lsu_addr_i[1:0];
          end
        end
        REQ: begin
          if (data_gnt_i) begin
            state      <= WAIT_RVALID;
            data_req_o <= 1'b0;
          end
        end
        WAIT_RVALID: begin
          if (data_rvalid_i) begin
            state        <= IDLE;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_addr_o  <= '0;
            data_wdata_o <= 32'h0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes expectations from a
// byte-level memory model, a memory responder and a monitor check the DUT.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk_i, rst_i;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_data_i, lsu_data_o;
  logic        lsu_stall_req_o, lsu_err_o;
  logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
    .lsu_stall_req_o(lsu_stall_req_o), .lsu_err_o(lsu_err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mem_txn_t;

  mem_txn_t    mem_q[$];
  logic [31:0] res_q[$];
  int          err_q[$];
  logic [31:0] mem [int];

  int n_cmp = 0;
  int n_err = 0;
  int force_gd, force_rd;
  bit drop_rvalid, in_wait, late_rvalid;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_nbytes(input logic [2:0] size);
    case (size)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit model_legal(input logic we, input logic [2:0] size);
    if (we) return (size <= 3'd2);
    return (size <= 3'd2) || (size == 3'd4) || (size == 3'd5);
  endfunction

  function automatic logic [31:0] mem_word(input int idx);
    if (!mem.exists(idx)) mem[idx] = $urandom;
    return mem[idx];
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] size,
                                             input int off);
    int nb = model_nbytes(size);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = word[8*(off+k) +: 8];
    if (nb < 4 && !size[2] && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] data, input bit drop);
    int nb, off, n;
    bit ok;
    mem_txn_t t;
    logic [31:0] word;
    nb  = model_nbytes(size);
    off = int'(addr[1:0]);
    ok  = model_legal(we, size) && (off % nb == 0);
    @(posedge clk_i); #1;
    if (!ok) begin
      err_q.push_back(1);
      lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; lsu_data_i = data;
      @(negedge clk_i);
      check("err_no_stall", lsu_stall_req_o, 0);
      @(posedge clk_i); #1 lsu_req_i = 1'b0;
      @(negedge clk_i);
      check("err_no_req", data_req_o, 0);
      check("err_be_idle", data_be_o, 0);
      return;
    end
    word    = mem_word(int'(addr >> 2));
    t.addr  = addr & ~32'h3;
    t.we    = we;
    t.be    = 4'b0000;
    t.wdata = 32'h0;
    for (int k = 0; k < nb; k++) t.be[off+k] = 1'b1;
    for (int j = 0; j < 4; j++) t.wdata[8*j +: 8] = data[8*(j % nb) +: 8];
    t.rdata = we ? $urandom : word;
    mem_q.push_back(t);
    if (!drop) res_q.push_back(we ? 32'h0 : model_load(word, size, off));
    if (we) begin
      for (int k = 0; k < nb; k++) word[8*(off+k) +: 8] = data[8*k +: 8];
      mem[int'(addr >> 2)] = word;
    end
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; lsu_data_i = data;
    @(negedge clk_i);
    check("stall_accept", lsu_stall_req_o, 1);
    if (drop) return;
    n = 1;
    while (lsu_stall_req_o && n < 64) begin
      @(negedge clk_i);
      if (lsu_stall_req_o) n++;
    end
    check("stall_released", lsu_stall_req_o, 0);
    if (force_gd >= 0) check("stall_cycles", n, 2 + force_gd + force_rd);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   data_req_o, 0);
    check({tag, "_we"},    data_we_o, 0);
    check({tag, "_be"},    data_be_o, 0);
    check({tag, "_addr"},  data_addr_o, 0);
    check({tag, "_wdata"}, data_wdata_o, 0);
    check({tag, "_err"},   lsu_err_o, 0);
    check({tag, "_stall"}, lsu_stall_req_o, 0);
    check({tag, "_data"},  lsu_data_o, 0);
  endtask

  initial begin : driver
    int n;
    rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'b000;
    lsu_addr_i = 32'h0; lsu_data_i = 32'h0;
    force_gd = 0; force_rd = 0; drop_rvalid = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i); #1 rst_i = 1'b0;

    do_access(1'b1, LDST_W, 32'h10, 32'hDEADBEEF, 1'b0);
    do_access(1'b1, LDST_B, 32'h13, 32'h000000A5, 1'b0);
    mem[4] = 32'h1234_80FF;
    do_access(1'b0, LDST_B,  32'h11, 32'h0, 1'b0);
    do_access(1'b0, LDST_BU, 32'h11, 32'h0, 1'b0);
    do_access(1'b0, LDST_HU, 32'h12, 32'h0, 1'b0);
    do_access(1'b0, LDST_H,  32'h12, 32'h0, 1'b0);
    do_access(1'b0, LDST_W,  32'h22, 32'h0, 1'b0);
    do_access(1'b0, 3'b011,  32'h10, 32'h0, 1'b0);
    do_access(1'b1, 3'b100,  32'h10, 32'h5A, 1'b0);
    force_gd = 3; force_rd = 2;
    do_access(1'b0, LDST_W, 32'h20, 32'h0, 1'b0);
    do_access(1'b1, LDST_H, 32'h26, 32'h0000BEEF, 1'b0);

    force_gd = -1; force_rd = -1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i); #1 lsu_req_i = 1'b0;
      end
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                32'($urandom_range(0, 63)), $urandom, 1'b0);
    end

    // Reset while waiting for rvalid; the late rvalid must be ignored.
    force_gd = 0; force_rd = 0; drop_rvalid = 1'b1;
    do_access(1'b0, LDST_W, 32'h8, 32'h0, 1'b1);
    n = 0;
    while (!in_wait && n < 20) begin @(negedge clk_i); n++; end
    check("reached_wait_rvalid", in_wait, 1);
    @(posedge clk_i); #1 rst_i = 1'b1; lsu_req_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("mid_reset");
    drop_rvalid = 1'b0;
    n = 0;
    while (in_wait && n < 20) begin @(negedge clk_i); n++; end
    do_access(1'b0, LDST_H, 32'h4, 32'h0, 1'b0);

    @(posedge clk_i); #1 lsu_req_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("mem_q_drained", mem_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- memory responder ----------------
  initial begin : mem_resp
    mem_txn_t t;
    int gd, rd, n;
    bit late;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    in_wait = 1'b0; late_rvalid = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (data_req_o) begin
        if (mem_q.size() == 0) begin
          check("req_expected", mem_q.size(), 1);
          t.addr = data_addr_o; t.we = data_we_o; t.be = data_be_o;
          t.wdata = data_wdata_o; t.rdata = 32'h0;
        end else begin
          t = mem_q.pop_front();
          check("mem_addr", data_addr_o, t.addr);
          check("mem_we", data_we_o, t.we);
          check("mem_be", data_be_o, t.be);
          if (t.we) check("mem_wdata", data_wdata_o, t.wdata);
        end
        gd   = (force_gd >= 0) ? force_gd : $urandom_range(0, 3);
        rd   = (force_rd >= 0) ? force_rd : $urandom_range(0, 2);
        late = drop_rvalid;
        for (int i = 0; i < gd; i++) begin
          @(negedge clk_i);
          check("req_held", data_req_o, 1);
          check("addr_held", data_addr_o, t.addr);
          check("be_held", data_be_o, t.be);
          check("stall_req", lsu_stall_req_o, 1);
          @(posedge clk_i); #1;
        end
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        check("stall_gnt", lsu_stall_req_o, 1);
        @(posedge clk_i); #1 data_gnt_i = 1'b0;
        for (int i = 0; i < rd; i++) begin
          @(negedge clk_i);
          check("req_dropped", data_req_o, 0);
          check("stall_wait", lsu_stall_req_o, 1);
          @(posedge clk_i); #1;
        end
        if (late) begin
          in_wait = 1'b1;
          n = 0;
          while (drop_rvalid && n < 100) begin @(posedge clk_i); #1; n++; end
          late_rvalid = 1'b1;
        end
        data_rvalid_i = 1'b1;
        data_rdata_i  = t.rdata;
        @(negedge clk_i);
        check("req_low_rvalid", data_req_o, 0);
        @(posedge clk_i); #1;
        data_rvalid_i = 1'b0; data_rdata_i = $urandom;
        in_wait = 1'b0; late_rvalid = 1'b0;
        @(negedge clk_i);
        check("no_rereq", data_req_o, 0);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [31:0] exp;
    forever begin
      @(negedge clk_i);
      if (data_rvalid_i) begin
        if (late_rvalid) begin
          check("late_rvalid_data", lsu_data_o, 0);
          check("late_rvalid_stall", lsu_stall_req_o, 0);
        end else if (res_q.size() == 0) begin
          check("result_expected", res_q.size(), 1);
        end else begin
          exp = res_q.pop_front();
          check("load_data", lsu_data_o, exp);
          check("stall_rvalid", lsu_stall_req_o, 0);
        end
      end
      if (lsu_err_o) begin
        if (err_q.size() == 0) check("spurious_err", lsu_err_o, 0);
        else void'(err_q.pop_front());
      end
    end
  end

endmodule
